mod_scheduler: RTL and testbench

//  Sequences the digital modulation datapath on clk_120M. Generates the symbol strobe and PRBS

---
 rtl/mod_scheduler.sv | 130 +++++++++++++
 tb/tb_mod_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mod_scheduler.sv
// Modulation sequencer: free-running symbol strobe and PRBS7 baseband bit, plus a
// handshake-driven mode switch that lands on a symbol boundary behind a mid-scale guard.
module mod_scheduler #(
    parameter int unsigned    DW       = 12,
    parameter int unsigned    SYM_DIV  = 1200,
    parameter int unsigned    GUARD    = 16,
    parameter logic [DW-1:0]  MIDSCALE = 12'd2048
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode_req_valid,
    input  logic [1:0]    mode_req,
    output logic          mode_req_ready,
    input  logic [DW-1:0] ask_data,
    input  logic [DW-1:0] fsk_data,
    input  logic [DW-1:0] bpsk_data,
    output logic          base_bit,
    output logic          sym_stb,
    output logic [1:0]    cur_mode,
    output logic          busy,
    output logic [DW-1:0] adc_data
);

    localparam int unsigned CW = $clog2(SYM_DIV);
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SYM_DIV - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_GUARD
    } state_t;

    typedef enum logic [1:0] {
        M_OFF  = 2'd0,
        M_ASK  = 2'd1,
        M_FSK  = 2'd2,
        M_BPSK = 2'd3
    } mode_t;

    logic [CW-1:0] sym_cnt;
    logic [CW-1:0] cnt_next;
    logic [6:0]    lfsr;
    logic [GW-1:0] guard_cnt;
    state_t        state;
    mode_t         cur;
    mode_t         pend_mode;
    mode_t         req_mode;

    always_comb begin
        cnt_next = '0;
        if (sym_cnt != CNT_LAST) begin
            cnt_next = sym_cnt + CW'(1);
        end
    end

    // Strobe is computed from the next count so it is high in the same cycle sym_cnt sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
            sym_stb <= 1'b0;
            lfsr    <= 7'h7F;
        end else begin
            sym_cnt <= cnt_next;
            sym_stb <= (cnt_next == CNT_LAST);
            if (sym_stb) begin
                lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            end
        end
    end

    assign base_bit = lfsr[6];
    assign req_mode = mode_t'(mode_req);
    assign cur_mode = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            cur            <= M_OFF;
            pend_mode      <= M_OFF;
            guard_cnt      <= '0;
            mode_req_ready <= 1'b1;
            busy           <= 1'b0;
            adc_data       <= MIDSCALE;
        end else begin
            case (state)
                S_RUN: begin
                    if (mode_req_valid && mode_req_ready && (req_mode != cur)) begin
                        pend_mode      <= req_mode;
                        state          <= S_PEND;
                        mode_req_ready <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                S_PEND: begin
                    if (sym_stb) begin
                        state     <= S_GUARD;
                        guard_cnt <= GUARD_LOAD;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt == '0) begin
                        cur            <= pend_mode;
                        state          <= S_RUN;
                        mode_req_ready <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                default: begin
                    state <= S_RUN;
                end
            endcase

            if (state == S_GUARD) begin
                adc_data <= MIDSCALE;
            end else begin
                case (cur)
                    M_ASK:   adc_data <= ask_data;
                    M_FSK:   adc_data <= fsk_data;
                    M_BPSK:  adc_data <= bpsk_data;
                    default: adc_data <= MIDSCALE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod_scheduler.sv
// Directed bench for mod_scheduler: symbol timing, PRBS7, mode changes with guard, reset abort.
module tb_mod_scheduler;

    localparam int DW      = 12;
    localparam int SYM_DIV = 1200;
    localparam int GUARD   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_req_valid;
    logic [1:0]    mode_req;
    logic          mode_req_ready;
    logic [DW-1:0] ask_data;
    logic [DW-1:0] fsk_data;
    logic [DW-1:0] bpsk_data;
    logic          base_bit;
    logic          sym_stb;
    logic [1:0]    cur_mode;
    logic          busy;
    logic [DW-1:0] adc_data;

    mod_scheduler #(
        .DW      (DW),
        .SYM_DIV (SYM_DIV),
        .GUARD   (GUARD),
        .MIDSCALE(12'd2048)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_req_valid(mode_req_valid),
        .mode_req      (mode_req),
        .mode_req_ready(mode_req_ready),
        .ask_data      (ask_data),
        .fsk_data      (fsk_data),
        .bpsk_data     (bpsk_data),
        .base_bit      (base_bit),
        .sym_stb       (sym_stb),
        .cur_mode      (cur_mode),
        .busy          (busy),
        .adc_data      (adc_data)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    logic [6:0]    lfsr_m;
    logic          stb_prev;
    logic [DW-1:0] last_ask, last_fsk, last_bpsk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sel(input int m);
        case (m)
            1:       return last_ask;
            2:       return last_fsk;
            3:       return last_bpsk;
            default: return 12'd2048;
        endcase
    endfunction

    // cyc = number of rising edges since reset release; samples taken on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        last_ask  = ask_data;
        last_fsk  = fsk_data;
        last_bpsk = bpsk_data;
        ask_data  = DW'($urandom);
        fsk_data  = DW'($urandom);
        bpsk_data = DW'($urandom);
        if (stb_prev) lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
        stb_prev = ((cyc % SYM_DIV) == SYM_DIV - 1);
        check("sym_stb", sym_stb, stb_prev);
        check("base_bit", base_bit, lfsr_m[6]);
    endtask

    task automatic check_reset_values();
        check("rst_adc", adc_data, 12'd2048);
        check("rst_mode", cur_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", mode_req_ready, 1);
        check("rst_stb", sym_stb, 0);
        check("rst_base", base_bit, 1);
    endtask

    task automatic restart_model();
        cyc      = 0;
        lfsr_m   = 7'h7F;
        stb_prev = 1'b0;
    endtask

    // t_req: raise valid after that sample (-1 = already held); t_acc: edge of the transfer;
    // t_stb: the sym_stb cycle that opens the guard; t_hold: raise a held mode=1 request.
    task automatic run_change(input int old_m, input int new_m, input int t_req, input int t_acc,
                              input int t_stb, input int t_end, input int t_hold, input int abort_at);
        int   g_end;
        logic exp_ready;
        g_end = t_stb + 1 + GUARD;
        while (cyc < t_end) begin
            tick();
            if (abort_at != 0 && cyc == abort_at) return;
            exp_ready = (cyc < t_acc) || (cyc >= g_end);
            check("ready", mode_req_ready, exp_ready);
            check("busy", busy, !exp_ready);
            check("cur_mode", cur_mode, (cyc >= g_end) ? new_m : old_m);
            if (cyc <= t_stb + 1)  check("adc_old", adc_data, sel(old_m));
            else if (cyc <= g_end) check("adc_guard", adc_data, 12'd2048);
            else                   check("adc_new", adc_data, sel(new_m));
            if (cyc == t_req) begin
                mode_req_valid = 1'b1;
                mode_req       = 2'(new_m);
            end
            if (cyc == t_acc) mode_req_valid = 1'b0;
            if (cyc == t_hold) begin
                mode_req_valid = 1'b1;
                mode_req       = 2'd1;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        mode_req_valid = 1'b0;
        mode_req       = 2'd0;
        ask_data       = '0;
        fsk_data       = '0;
        bpsk_data      = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        restart_model();

        // Idle through cyc 100, then OFF -> ASK requested at sym_cnt=100.
        run_change(0, 1, 100, 101, 1199, 1230, -1, 0);

        // Request equal to current mode: accepted, nothing changes.
        mode_req_valid = 1'b1;
        mode_req       = 2'd1;
        tick();
        check("eq_ready", mode_req_ready, 1);
        check("eq_busy", busy, 0);
        check("eq_mode", cur_mode, 1);
        check("eq_adc", adc_data, sel(1));
        mode_req_valid = 1'b0;
        tick();
        check("eq_busy2", busy, 0);
        check("eq_adc2", adc_data, sel(1));

        // ASK -> BPSK requested at sym_cnt=100; guard visible on the bus.
        run_change(1, 3, 1300, 1301, 2399, 2430, -1, 0);

        // BPSK -> FSK transferred during a sym_stb cycle: guard waits a full symbol.
        // A mode=1 request is held from inside that guard.
        run_change(3, 2, 3599, 3600, 4799, 4816, 4805, 0);

        // Held request is taken as soon as ready returns; second change sequence.
        run_change(2, 1, -1, 4817, 5999, 6030, -1, 0);

        // ASK -> BPSK aborted by reset in the middle of the guard.
        run_change(1, 3, 6100, 6101, 7199, 7300, -1, 7205);
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        restart_model();
        repeat (SYM_DIV + 100) begin
            tick();
            check("post_mode", cur_mode, 0);
            check("post_busy", busy, 0);
            check("post_ready", mode_req_ready, 1);
            check("post_adc", adc_data, 12'd2048);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
